pipelined_data_memory: RTL and testbench

PIPELINED_DATA_MEMORY -- requirements
Module: pipelined_data_memory

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_lane_align.sv | 74 +++++++
 rtl/pipelined_data_memory.sv | 146 ++++++++++++++
 tb/tb_pipelined_data_memory.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and bounds for the pipelined data memory.
// Access-size encoding, FSM state encoding and legal LATENCY range.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;   // holds LATENCY_MAX

endpackage

// File: rtl/mem_lane_align.sv
// Purely combinational lane logic: byte-enable generation, store-data
// shifting into lanes, load extraction with sign/zero extension, and
// alignment / size legality checks.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]                    size,
  input  logic [$clog2(DATA_W/8)-1:0]   offset,
  input  logic                          is_unsigned,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [DATA_W-1:0]             rword,
  output logic [DATA_W/8-1:0]           be,
  output logic [DATA_W-1:0]             wdata_sh,
  output logic [DATA_W-1:0]             rdata,
  output logic                          misaligned,
  output logic                          size_illegal
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  size_e             sz;
  logic [NB-1:0]     lane_mask;
  logic [OFF_W-1:0]  align_mask;
  logic [DATA_W-1:0] val_mask;
  logic [DATA_W-1:0] shifted;
  logic              sign_bit;

  assign sz = size_e'(size);

  // Decode size into lane, alignment and value masks; build lane outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    lane_mask    = '0;
    align_mask   = '0;
    val_mask     = '0;
    sign_bit     = 1'b0;
    size_illegal = 1'b0;
    shifted      = rword >> {offset, 3'b000};
    case (sz)
      SZ_BYTE: begin
        lane_mask = NB'(1);
        val_mask  = DATA_W'(8'hFF);
        sign_bit  = shifted[7];
      end
      SZ_HALF: begin
        lane_mask  = NB'(2'b11);
        align_mask = OFF_W'(1);
        val_mask   = DATA_W'(16'hFFFF);
        sign_bit   = shifted[15];
      end
      SZ_WORD: begin
        lane_mask  = NB'(4'hF);
        align_mask = OFF_W'(3);
        val_mask   = DATA_W'(32'hFFFF_FFFF);
        sign_bit   = shifted[31];
      end
      default: begin
        lane_mask    = '1;
        align_mask   = '1;
        val_mask     = '1;
        size_illegal = (DATA_W != 64);
      end
    endcase
    misaligned = |(offset & align_mask);
    be         = lane_mask << offset;
    wdata_sh   = wdata << {offset, 3'b000};
    rdata      = (shifted & val_mask) |
                 ((sign_bit && !is_unsigned) ? ~val_mask : '0);
  end

endmodule

// File: rtl/pipelined_data_memory.sv
// Single-outstanding data memory with fixed request-to-response latency.
// Stores commit and loads snapshot on the acceptance edge; the response
// appears LATENCY cycles after the accept cycle and is held under
// backpressure. Initial memory contents are undefined.
module pipelined_data_memory
  import mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 16384,
  parameter int LATENCY   = 2,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
    $error("DATA_W must be 32 or 64");
  end
  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("LATENCY out of range 1..15");
  end

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;

  logic [31:0]       word_idx;
  logic [OFF_W-1:0]  offset;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] rword;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata_sh;
  logic [DATA_W-1:0] rdata_ext;
  logic              misaligned;
  logic              size_illegal;
  logic              out_of_range;
  logic              req_err;
  logic              accept;
  logic              mem_we;

  assign word_idx     = req_addr >> OFF_W;
  assign offset       = req_addr[OFF_W-1:0];
  assign mem_idx      = word_idx[IDX_W-1:0];
  assign out_of_range = (word_idx >= 32'(MEM_DEPTH));
  assign rword        = mem[mem_idx];
  assign req_err      = misaligned | size_illegal | out_of_range;
  assign accept       = req_valid && req_ready_q;
  assign mem_we       = accept && req_write && !req_err;

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .size         (req_size),
    .offset       (offset),
    .is_unsigned  (req_unsigned),
    .wdata        (req_wdata),
    .rword        (rword),
    .be           (be),
    .wdata_sh     (wdata_sh),
    .rdata        (rdata_ext),
    .misaligned   (misaligned),
    .size_illegal (size_illegal)
  );

  // Byte-lane store on acceptance.
  // NOTE: the memory array is deliberately not reset; contents survive reset_n and map onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[mem_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
      end
    end
  end

  // Request/response FSM with latency counter and registered handshake outputs.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_ready_q  <= 1'b0;
            resp_err_q   <= req_err;
            resp_rdata_q <= (req_err || req_write) ? '0 : rdata_ext;
            if (LATENCY == 1) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_pipelined_data_memory.sv
// Directed bench for pipelined_data_memory: a 32-bit and a 64-bit instance
// share one request stream; each response is checked against hand values.
module tb_pipelined_data_memory;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        resp_ready;

  logic        req_ready32, resp_valid32, resp_err32;
  logic [31:0] resp_rdata32;
  logic        req_ready64, resp_valid64, resp_err64;
  logic [63:0] resp_rdata64;

  int errors = 0;
  int checks = 0;

  logic [63:0] rd32, rd64;
  logic        er32, er64;

  pipelined_data_memory #(.DATA_W(32), .LATENCY(2)) dut32 (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready32),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata[31:0]),
    .resp_valid   (resp_valid32),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata32),
    .resp_err     (resp_err32)
  );

  pipelined_data_memory #(.DATA_W(64), .MEM_DEPTH(256), .LATENCY(2)) dut64 (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready64),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid64),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata64),
    .resp_err     (resp_err64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request with resp_ready=1: accept, one WAIT cycle, RESP, handshake.
  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [1:0] sz, input logic uns, input logic [63:0] wd);
    req_valid    = 1'b1;
    req_write    = wr;
    req_addr     = addr;
    req_size     = sz;
    req_unsigned = uns;
    req_wdata    = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "/wait_valid"}, 64'({resp_valid32, resp_valid64}), 64'd0);
    check({tag, "/wait_ready"}, 64'({req_ready32, req_ready64}), 64'd0);
    @(posedge clk); #1;
    check({tag, "/resp_valid"}, 64'({resp_valid32, resp_valid64}), 64'b11);
    rd32 = 64'(resp_rdata32);
    rd64 = resp_rdata64;
    er32 = resp_err32;
    er64 = resp_err64;
    @(posedge clk); #1;
    check({tag, "/idle"}, 64'({resp_valid32, req_ready32}), 64'b01);
  endtask

  initial begin
    reset_n      = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = '0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_wdata    = '0;
    resp_ready   = 1'b1;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst/valid", 64'({resp_valid32, resp_valid64}), 64'd0);
    check("rst/err",   64'({resp_err32, resp_err64}), 64'd0);
    check("rst/rdata32", 64'(resp_rdata32), 64'd0);
    check("rst/rdata64", resp_rdata64, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst/ready", 64'({req_ready32, req_ready64}), 64'b11);

    // Word store/load round trip
    do_req("st_word", 1'b1, 32'h100, 2'd2, 1'b0, 64'hDEADBEEF);
    check("st_word/rdata", rd32, 64'd0);
    check("st_word/err", 64'(er32), 64'd0);
    do_req("ld_word", 1'b0, 32'h100, 2'd2, 1'b0, 64'd0);
    check("ld_word/rdata", rd32, 64'hDEADBEEF);
    check("ld_word/err", 64'(er32), 64'd0);

    // Byte store over a cleared word, signed/unsigned byte loads
    do_req("clr_word", 1'b1, 32'h100, 2'd2, 1'b0, 64'h0);
    do_req("st_byte", 1'b1, 32'h101, 2'd0, 1'b0, 64'h80);
    check("st_byte/err", 64'(er32), 64'd0);
    do_req("ld_byte_s", 1'b0, 32'h101, 2'd0, 1'b0, 64'd0);
    check("ld_byte_s/rdata", rd32, 64'hFFFFFF80);
    do_req("ld_byte_u", 1'b0, 32'h101, 2'd0, 1'b1, 64'd0);
    check("ld_byte_u/rdata", rd32, 64'h80);
    do_req("ld_word2", 1'b0, 32'h100, 2'd2, 1'b0, 64'd0);
    check("ld_word2/rdata", rd32, 64'h00008000);

    // Aligned half store into upper lanes, signed half load
    do_req("st_half", 1'b1, 32'h102, 2'd1, 1'b0, 64'hABCD);
    check("st_half/err", 64'(er32), 64'd0);
    do_req("ld_half_s", 1'b0, 32'h102, 2'd1, 1'b0, 64'd0);
    check("ld_half_s/rdata", rd32, 64'hFFFFABCD);

    // Misaligned half store: error, no write
    do_req("st_mis", 1'b1, 32'h103, 2'd1, 1'b0, 64'h1234);
    check("st_mis/err", 64'(er32), 64'd1);
    check("st_mis/rdata", rd32, 64'd0);
    do_req("ld_after_mis", 1'b0, 32'h100, 2'd2, 1'b0, 64'd0);
    check("ld_after_mis/rdata", rd32, 64'hABCD8000);

    // Out-of-range word load on the 32-bit instance
    do_req("ld_range32", 1'b0, 32'h0001_0000, 2'd2, 1'b0, 64'd0);
    check("ld_range32/err", 64'(er32), 64'd1);
    check("ld_range32/rdata", rd32, 64'd0);

    // Backpressure: hold resp_ready low for 5 cycles with a competing request
    resp_ready   = 1'b0;
    req_valid    = 1'b1;
    req_write    = 1'b0;
    req_addr     = 32'h100;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bp/first_valid", 64'(resp_valid32), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp/hold_valid", 64'(resp_valid32), 64'd1);
      check("bp/hold_rdata", 64'(resp_rdata32), 64'hABCD8000);
      check("bp/hold_err", 64'(resp_err32), 64'd0);
      check("bp/hold_ready", 64'(req_ready32), 64'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp/release", 64'({resp_valid32, req_ready32}), 64'b01);
    @(posedge clk); #1;
    check("bp/no_extra", 64'({resp_valid32, req_ready32}), 64'b01);

    // Reset during WAIT drops the response
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h100;
    req_size  = 2'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstw/in_wait", 64'(resp_valid32), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    check("rstw/rdata_clr", 64'(resp_rdata32), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rstw/held_valid", 64'({resp_valid32, resp_valid64}), 64'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rstw/after_valid", 64'({resp_valid32, resp_valid64}), 64'd0);
      check("rstw/after_ready", 64'({req_ready32, req_ready64}), 64'b11);
    end
    do_req("rstw/mem_kept", 1'b0, 32'h100, 2'd2, 1'b0, 64'd0);
    check("rstw/mem_kept_rdata", rd32, 64'hABCD8000);

    // 64-bit: range error, illegal double on 32-bit, double round trip
    do_req("ld_range64", 1'b0, 32'd2048, 2'd3, 1'b0, 64'd0);
    check("ld_range64/err", 64'(er64), 64'd1);
    check("ld_range64/rdata", rd64, 64'd0);
    check("dbl_on_32/err", 64'(er32), 64'd1);
    do_req("st_dbl", 1'b1, 32'h8, 2'd3, 1'b0, 64'h0123456789ABCDEF);
    check("st_dbl/err", 64'(er64), 64'd0);
    do_req("ld_dbl", 1'b0, 32'h8, 2'd3, 1'b0, 64'd0);
    check("ld_dbl/rdata", rd64, 64'h0123456789ABCDEF);
    check("ld_dbl/err", 64'(er64), 64'd0);
    do_req("ld_w64_lo", 1'b0, 32'h8, 2'd2, 1'b0, 64'd0);
    check("ld_w64_lo/rdata", rd64, 64'hFFFFFFFF89ABCDEF);
    do_req("ld_w64_hi", 1'b0, 32'hC, 2'd2, 1'b0, 64'd0);
    check("ld_w64_hi/rdata", rd64, 64'h0000000001234567);
    do_req("ld_b64", 1'b0, 32'hF, 2'd0, 1'b1, 64'd0);
    check("ld_b64/rdata", rd64, 64'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
